// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared float field constants and float_packer stage-register types
package cordic_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
    } s1_t;

    // Guard and sticky bits are only carried when rounding is built in.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [4:0]        pos;
        logic [MANT_W-1:0] mant;
`ifdef PACKER_ROUND_EN
        logic              guard;
        logic              sticky;
`endif
    } s2_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational leading-one index and zero flag of a 32-bit word
module lzc32 (
    input  logic [31:0] data,
    output logic [4:0]  pos,
    output logic        zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) begin
                pos = 5'(i);
            end
        end
        zero = (data == 32'd0);
    end

endmodule

// File: rtl/float_packer.sv
// rtl/float_packer.sv - 3-stage fixed-point to IEEE-754 single packer; PACKER_ROUND_EN selects RNE over truncation
module float_packer
    import cordic_pkg::*;
#(
    parameter int FRACTIONAL_BITS = 29,
    parameter bit SIGNED          = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    logic s1_valid;
    logic s2_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;
    logic s1_en;
    logic s2_en;
    logic s3_en;

    // A stage may load whenever it is empty or its content moves on this edge.
    assign s3_en    = !out_valid || out_ready;
    assign s2_en    = !s2_valid || s3_en;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        s1_d.sign = SIGNED ? in_data[31] : 1'b0;
        s1_d.mag  = s1_d.sign ? (~in_data + 32'd1) : in_data;
    end

    logic [4:0]  lz_pos;
    logic        lz_zero;
    logic [31:0] shifted;

    lzc32 u_lzc (
        .data (s1_q.mag),
        .pos  (lz_pos),
        .zero (lz_zero)
    );

    always_comb begin
        shifted     = s1_q.mag << (5'd31 - lz_pos);
        s2_d.sign   = s1_q.sign;
        s2_d.zero   = lz_zero;
        s2_d.pos    = lz_pos;
        s2_d.mant   = 23'(shifted >> 8);
`ifdef PACKER_ROUND_EN
        s2_d.guard  = shifted[7];
        s2_d.sticky = |shifted[6:0];
`endif
    end

    logic [8:0]        exp9;
    logic [MANT_W-1:0] mant_o;
    float_t            pack;
`ifdef PACKER_ROUND_EN
    logic              inc;
    logic [MANT_W:0]   mant_sum;
`endif

    always_comb begin
        exp9 = 9'(FLOAT_BIAS) + 9'(s2_q.pos) - 9'(FRACTIONAL_BITS);
`ifdef PACKER_ROUND_EN
        inc      = s2_q.guard && (s2_q.sticky || s2_q.mant[0]);
        mant_sum = {1'b0, s2_q.mant} + {{MANT_W{1'b0}}, inc};
        // A carry out of the mantissa leaves it all-zero and bumps the exponent.
        if (mant_sum[MANT_W]) begin
            exp9 = exp9 + 9'd1;
        end
        mant_o = mant_sum[MANT_W-1:0];
`else
        mant_o = s2_q.mant;
`endif
        pack.sign = s2_q.sign;
        pack.exp  = 8'(exp9);
        pack.mant = mant_o;
        if (s2_q.zero) begin
            pack = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s2_d;
                end
            end
            if (s3_en) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_data <= pack;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_packer.sv
// tb/tb_float_packer.sv - directed self-checking bench for float_packer
module tb_float_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
    logic [31:0] u_in_data, u_out_data;

    int checks = 0;
    int failures = 0;

`ifdef PACKER_ROUND_EN
    localparam logic [31:0] E_TIE_ODD = 32'h3F80_0002;
    localparam logic [31:0] E_CARRY   = 32'h4000_0000;
    localparam logic [31:0] E_UMAX    = 32'h4100_0000;
`else
    localparam logic [31:0] E_TIE_ODD = 32'h3F80_0001;
    localparam logic [31:0] E_CARRY   = 32'h3FFF_FFFF;
    localparam logic [31:0] E_UMAX    = 32'h40FF_FFFF;
`endif

    always #5 clk = ~clk;

    float_packer #(.FRACTIONAL_BITS(29), .SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    float_packer #(.FRACTIONAL_BITS(29), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, e);
    endtask

    logic [31:0] bw [5];
    logic [31:0] be [5];
    int          sent, rx;
    logic        rdy, seen;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bw = '{32'h2000_0000, 32'h4000_0000, 32'h1000_0000, 32'hE000_0000, 32'h0800_0000};
        be = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h3E80_0000};

        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        convert("one",      32'h2000_0000, 32'h3F80_0000);
        convert("neg_half", 32'hF000_0000, 32'hBF00_0000);
        convert("zero",     32'h0000_0000, 32'h0000_0000);
        convert("tie_even", 32'h2000_0020, 32'h3F80_0000);
        convert("tie_odd",  32'h2000_0060, E_TIE_ODD);
        convert("carry",    32'h3FFF_FFFF, E_CARRY);
        convert("min_neg",  32'h8000_0000, 32'hC080_0000);

        @(negedge clk);
        u_in_valid = 1'b1;
        u_in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        u_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("umax_valid", 32'(u_out_valid), 32'd1);
        check("umax_data", u_out_data, E_UMAX);

        // Back-pressure: only three words fit with the output stalled.
        @(negedge clk);
        out_ready = 1'b0;
        sent = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bw[sent];
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) sent++;
        end
        @(negedge clk);
        #1;
        check("bp_accepted", 32'(sent), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", out_data, be[0]);
        @(negedge clk);
        #1;
        check("bp_stable_data", out_data, be[0]);

        rx = 0;
        for (int k = 0; k < 30 && rx < 5; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 5) begin
                in_valid = 1'b1;
                in_data  = bw[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            rdy = in_ready && in_valid;
            if (out_valid) begin
                check($sformatf("bp_out%0d", rx), out_data, be[rx]);
                rx++;
            end
            @(posedge clk);
            if (rdy) sent++;
        end
        in_valid = 1'b0;
        check("bp_rx_count", 32'(rx), 32'd5);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("bp_no_dup", 32'(seen), 32'd0);

        // Reset with three words in flight.
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bw[k];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("rstm_pre_valid", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstm_out_valid", 32'(out_valid), 32'd0);
        check("rstm_out_data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rstm_no_stale", 32'(seen), 32'd0);
        check("rstm_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_packer.md
# float_packer

Pipelined fixed-point to IEEE-754 single-precision converter that sits directly downstream of the CORDIC datapath. It takes the signed fixed-point result (FRACTIONAL_BITS fraction bits, same format the float-to-fixed unpacker produces) and returns a packed float. It has a valid/ready handshake and a three-stage pipeline: sign/magnitude, normalise, round/pack. It accepts one word per cycle when not back-pressured.

## Interface
- FRACTIONAL_BITS, 29, number of fraction bits in in_data (1..31)
- SIGNED, 1, 1: in_data is two's complement; 0: in_data is unsigned magnitude

- clk  in  1  clock; all registers on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data holds a word to convert
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  32  fixed-point operand
- out_valid  out  1  out_data holds a converted float
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}

## Operation
- Transfer on a port happens only when its valid and ready are both high on a rising clk edge.
- S1 (sign/magnitude):
  - sign = in_data[31] if SIGNED, else 0.
  - mag = |in_data| as a 32-bit unsigned value. 0x80000000 gives mag 0x80000000.
- S2 (normalise):
  - p = index of the leading one of mag, from the lzc32 sub-module.
  - norm = mag shifted so that bit p lands at bit 31.
  - zero flag = (mag == 0).
- S3 (round/pack):
  - mant = norm[30:8]; guard = norm[7]; sticky = OR of norm[6:0].
  - Round to nearest, ties to even: increment when guard and (sticky or mant[0]).
  - exp = 127 + p − FRACTIONAL_BITS, computed in 9 bits. Add 1 if the rounding increment carries out of the mantissa; the mantissa then becomes 0.
  - out_data = {sign, exp[7:0], mant}.
- Zero input gives exactly 0x00000000; the sign is forced to 0.
- Range: for FRACTIONAL_BITS 1..31, exp stays within 96..159. No denormal, infinity or NaN outputs exist, so none are generated.
- Stall rule: each stage holds while its successor is full and not advancing. in_ready = !S1_valid || S1 advances. The output register is S3.

## Timing
- Reset values: out_valid=0, out_data=0x00000000, all stage valids=0. in_ready=1 once reset deasserts.
- Latency: a word accepted at edge N loads S1 at N, S2 at N+1 and S3 at N+2. out_valid is high from edge N+2.
- Throughput: one word per cycle while out_ready=1.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- With out_ready held low, up to 3 words are held. in_ready then drops in the cycle after the third acceptance.
- A simultaneous accept at the input and emit at the output in the same cycle, while full, loses nothing.
- Reset asserted mid-stream clears all valids immediately (asynchronous). In-flight words are discarded and none are emitted after reset.
- in_ready is combinational from out_ready. There is no other combinational path from input to output.

## Configuration
- PACKER_ROUND_EN defined: S3 does round-to-nearest-even as described.
- PACKER_ROUND_EN undefined:
  - S3 truncates (round toward zero): mant = norm[30:8].
  - There is no increment and no exponent carry.
  - Latency is unchanged.

## Structure
- Shared package cordic_pkg holds:
  - constant FLOAT_BIAS=127 and the field widths EXP_W=8, MANT_W=23;
  - typedef float_t, a packed struct {sign, exp, mant};
  - stage-register structs s1_t and s2_t.
- Sub-module lzc32: purely combinational, 32-bit leading-one index plus a zero flag, instantiated in S2.

## Test plan
(FRACTIONAL_BITS=29, SIGNED=1)
- Basic conversion: 0x20000000 (1.0) → 0x3F800000. 0xF0000000 (−0.5) → 0xBF000000. 0x00000000 → 0x00000000. out_valid is high at edge N+2.
- Rounding:
  - 0x20000020 (exact tie, lsb even) → 0x3F800000.
  - 0x20000060 (tie, lsb odd) → 0x3F800002; without PACKER_ROUND_EN → 0x3F800001.
- Carry: 0x3FFFFFFF rounds to 0x40000000 (2.0). Without PACKER_ROUND_EN → 0x3FFFFFFF.
- Extremes:
  - 0x80000000 (−4.0) → 0xC0800000.
  - SIGNED=0 with 0xFFFFFFFF → 0x41000000 (8.0, rounded up).
- Back-pressure:
  - Offer 5 words while out_ready=0: exactly 3 are accepted, then in_ready=0.
  - Release out_ready: 5 results arrive in order with no duplicates.
- Reset mid-stream: assert reset with 3 words in flight → out_valid=0 immediately. No stale word appears after reset is released.
